// File: rtl/vardelay_pkg.sv
// ============================================================================
// vardelay_pkg: common helper functions for the vardelay block
// Revision: 1.0
// ============================================================================
`default_nettype none

package vardelay_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vardelay_sdpram.sv
// ============================================================================
// sdpram: simple dual-port RAM, registered read, read-before-write, no reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module sdpram
    import vardelay_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic                      re_i,
    input  logic [clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Both updates share one block so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/vardelay.sv
// ============================================================================
// vardelay: step-gated variable delay line (0..DMAX steps) over an sdpram
// Revision: 1.0
// ============================================================================
`default_nettype none

module vardelay
    import vardelay_pkg::*;
#(
    parameter int W    = 1,
    parameter int DMAX = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       step,
    input  logic [clog2(DMAX+1)-1:0]   dly,
    input  logic [W-1:0]               in,
    input  logic                       in_valid,
    output logic [W-1:0]               out,
    output logic                       out_valid
);

    localparam int AW = clog2(DMAX);
    localparam int DW = clog2(DMAX + 1);
    localparam logic [DW-1:0] FILL_MAX = DW'(DMAX);
    localparam logic [AW-1:0] PTR_LAST = AW'(DMAX - 1);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [DW-1:0] fill_q, fill_d;
    logic          gate_q, gate_d;
    logic          byp_q, byp_d;
    logic [W:0]    byp_word_q, byp_word_d;

    logic          adv;
    logic [DW-1:0] dly_eff;
    logic [DW:0]   ptr_x;
    logic [DW:0]   dly_x;
    logic [AW-1:0] raddr;
    logic [W:0]    rd_word;
    logic [W:0]    sel_word;

    assign adv     = step & ~clr;
    assign dly_eff = (dly > FILL_MAX) ? FILL_MAX : dly;
    assign ptr_x   = (DW+1)'(wptr_q);
    assign dly_x   = (DW+1)'(dly_eff);

    always_comb begin
        if (ptr_x >= dly_x) begin
            raddr = AW'(ptr_x - dly_x);
        end else begin
            raddr = AW'(ptr_x + (DW+1)'(DMAX) - dly_x);
        end
    end

    sdpram #(
        .WIDTH (W + 1),
        .DEPTH (DMAX)
    ) u_ram (
        .clk     (clk),
        .we_i    (adv),
        .waddr_i (wptr_q),
        .wdata_i ({in_valid, in}),
        .re_i    (adv),
        .raddr_i (raddr),
        .rdata_o (rd_word)
    );

    always_comb begin
        wptr_d     = wptr_q;
        fill_d     = fill_q;
        gate_d     = gate_q;
        byp_d      = byp_q;
        byp_word_d = byp_word_q;
        if (clr) begin
            wptr_d = '0;
            fill_d = '0;
            gate_d = 1'b0;
        end else if (step) begin
            wptr_d     = (wptr_q == PTR_LAST) ? '0 : wptr_q + AW'(1);
            fill_d     = (fill_q == FILL_MAX) ? fill_q : fill_q + DW'(1);
            gate_d     = (fill_q >= dly_eff);
            byp_d      = (dly_eff == '0);
            byp_word_d = {in_valid, in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            fill_q     <= '0;
            gate_q     <= 1'b0;
            byp_q      <= 1'b0;
            byp_word_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            fill_q     <= fill_d;
            gate_q     <= gate_d;
            byp_q      <= byp_d;
            byp_word_q <= byp_word_d;
        end
    end

    // The RAM read register is the data stage of the output; it is qualified
    // only by flops here, so out/out_valid never see an input combinationally.
    always_comb begin
        sel_word  = byp_q ? byp_word_q : rd_word;
        out_valid = gate_q & sel_word[W];
        out       = out_valid ? sel_word[W-1:0] : '0;
    end

endmodule

`default_nettype wire

// File: doc/vardelay.md
VARDELAY -- requirements
Module: vardelay

Interface
REQ-001 SHALL have parameter W, default 1, meaning data width in bits.
REQ-002 SHALL have parameter DMAX, default 16, meaning maximum delay in steps (legal range 2..1024).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous flush, active-high.
REQ-006 SHALL have port step  input  1  advance enable; no state changes when low.
REQ-007 SHALL have port dly  input  clog2(DMAX+1)  requested delay in steps.
REQ-008 SHALL have port in  input  W  data sample.
REQ-009 SHALL have port in_valid  input  1  qualifier for in.
REQ-010 SHALL have port out  output  W  delayed data, registered.
REQ-011 SHALL have port out_valid  output  1  qualifier for out, registered.

Function
REQ-012 SHALL, on each clk edge with step=1 and clr=0 (a "step"), write {in_valid, in} at wptr and advance wptr by 1, wrapping from DMAX-1 to 0.
REQ-013 SHALL, on step n, load out with the in sample presented at step n-dly; with dly=0 out SHALL equal the in of the same step (latency of 1 clk).
REQ-014 SHALL clamp dly values above DMAX to DMAX; no error flag.
REQ-015 SHALL sample dly on every step; a change takes effect on the step at which it is presented, with no flush and no invalidation.
REQ-016 SHALL maintain fill, counting steps since reset or clr and saturating at DMAX.
REQ-017 SHALL set out_valid = stored in_valid of the selected sample AND (fill >= effective dly); samples never written read as invalid.
REQ-018 SHALL drive out to 0 whenever out_valid is loaded as 0.
REQ-019 SHALL hold wptr, fill, out and out_valid unchanged on cycles with step=0.
REQ-020 SHALL give clr priority over step: when clr=1, set wptr=0, fill=0, out=0 and out_valid=0 on that edge; the sample presented on that cycle is discarded.
REQ-021 SHALL handle dly=DMAX by reading the location about to be overwritten, i.e. read-before-write on the same address.
REQ-022 SHALL have no combinational path from any input to out or out_valid.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force wptr=0, fill=0, out=0 and out_valid=0.
REQ-024 SHALL NOT require the RAM contents to be reset; the fill gating (REQ-017) masks stale contents.
REQ-025 SHALL resume stepping on the first rising clk edge after rst_n deasserts.

Structure
REQ-026 SHALL compute pointer and counter widths locally from DMAX; there are no shared typedefs or constants, and the clog2 constant function comes from the team's common header.
REQ-027 SHALL instantiate one sub-module, sdpram: a simple dual-port RAM of width W+1 and depth DMAX with registered read, read-before-write, and no reset.
REQ-028 SHALL keep wptr, the read-address arithmetic ((wptr - dly) mod DMAX, non-power-of-two safe), fill and the output registers in vardelay itself.

Verification
REQ-029 SHALL verify fixed delay: W=8, DMAX=16, dly=5, step=1, in=0,1,2,... -> out_valid rises after step 5 with out=0, then out=k-5 on step k.
REQ-030 SHALL verify dly=0 and dly=16: out=in of the same step for dly=0; for dly=16, out_valid first goes high at step 16 with out=0, and wrap works over 40 steps.
REQ-031 SHALL verify step gating: toggle step pseudo-randomly with dly=3 -> out equals the in of the 3rd-previous stepped cycle, and holds on idle cycles.
REQ-032 SHALL verify flush: assert clr after 10 steps at dly=4 -> out=0, out_valid=0 for the next 4 steps, then data taken from after the clr.
REQ-033 SHALL verify a dly change: switch from 2 to 6 mid-stream with fill=16 -> the next out is in[k-6] with no invalid gap; dly=20 behaves as 16.
REQ-034 SHALL verify async reset: pulse rst_n low mid-stream between clk edges -> out and out_valid drop to 0 immediately and refill as in REQ-029.
